// File: rtl/uart_frac_baud_gen.sv
// Fractional-N oversample/bit tick generator for the UART datapath.
// A shadow divisor is loaded at any time and becomes active only on a bit boundary or while idle.
module uart_frac_baud_gen #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 1000000,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_WIDTH  = 16,
    parameter int FRAC_BITS  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [DIV_WIDTH-1:0]          div_int,
    input  logic [FRAC_BITS-1:0]          div_frac,
    input  logic                          div_load,
    output logic                          os_tick,
    output logic                          baud_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] os_phase,
    output logic                          cfg_pending,
    output logic                          cfg_err
);

    localparam int     PW  = $clog2(OVERSAMPLE);
    localparam longint DEN = longint'(BAUD_RATE) * longint'(OVERSAMPLE);
    localparam longint D0  = ((longint'(CLK_FREQ) <<< FRAC_BITS) + DEN / 2) / DEN;
    localparam logic [DIV_WIDTH-1:0] DEF_INT  = DIV_WIDTH'(D0 >>> FRAC_BITS);
    localparam logic [FRAC_BITS-1:0] DEF_FRAC = FRAC_BITS'(D0);

    logic [DIV_WIDTH-1:0] act_int_q, act_int_d;
    logic [FRAC_BITS-1:0] act_frac_q, act_frac_d;
    logic [DIV_WIDTH-1:0] shd_int_q, shd_int_d;
    logic [FRAC_BITS-1:0] shd_frac_q, shd_frac_d;
    logic                 pending_q, pending_d;
    logic                 err_q, err_d;
    logic [FRAC_BITS-1:0] acc_q, acc_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [PW-1:0]        phase_q, phase_d;
    logic                 os_tick_q, os_tick_d;
    logic                 baud_tick_q, baud_tick_d;

    logic [FRAC_BITS:0]   frac_sum;
    logic [DIV_WIDTH:0]   last_cnt;
    logic                 period_end;
    logic                 is_baud;
    logic                 load_ok;
    logic                 load_bad;
    logic                 apply;

    // The carry of acc + act_frac stretches the current period by one cycle.
    assign frac_sum   = {1'b0, acc_q} + {1'b0, act_frac_q};
    assign last_cnt   = {1'b0, act_int_q} + (DIV_WIDTH+1)'(frac_sum[FRAC_BITS]) - (DIV_WIDTH+1)'(1);
    assign period_end = enable && ({1'b0, cnt_q} == last_cnt);
    // The bit ends on the tick that advances os_phase to its last index.
    assign is_baud    = period_end && (phase_q == PW'(OVERSAMPLE - 2));
    assign load_ok    = div_load && (div_int >= DIV_WIDTH'(2));
    assign load_bad   = div_load && (div_int <  DIV_WIDTH'(2));
    assign apply      = pending_q && (is_baud || !enable);

    always_comb begin
        act_int_d   = act_int_q;
        act_frac_d  = act_frac_q;
        shd_int_d   = shd_int_q;
        shd_frac_d  = shd_frac_q;
        pending_d   = pending_q;
        err_d       = err_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        os_tick_d   = 1'b0;
        baud_tick_d = 1'b0;

        if (load_ok) begin
            shd_int_d  = div_int;
            shd_frac_d = div_frac;
            pending_d  = 1'b1;
            err_d      = 1'b0;
        end else if (load_bad) begin
            err_d = 1'b1;
        end

        // A load on the apply edge stays pending; the older shadow value is applied.
        if (apply) begin
            act_int_d  = shd_int_q;
            act_frac_d = shd_frac_q;
            if (!load_ok) begin
                pending_d = 1'b0;
            end
        end

        if (!enable) begin
            cnt_d   = '0;
            acc_d   = '0;
            phase_d = '0;
        end else if (period_end) begin
            os_tick_d   = 1'b1;
            baud_tick_d = is_baud;
            cnt_d       = '0;
            phase_d     = phase_q + PW'(1);
            acc_d       = apply ? '0 : frac_sum[FRAC_BITS-1:0];
        end else begin
            cnt_d = cnt_q + DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_int_q   <= DEF_INT;
            act_frac_q  <= DEF_FRAC;
            shd_int_q   <= DEF_INT;
            shd_frac_q  <= DEF_FRAC;
            pending_q   <= 1'b0;
            err_q       <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
            phase_q     <= '0;
            os_tick_q   <= 1'b0;
            baud_tick_q <= 1'b0;
        end else begin
            act_int_q   <= act_int_d;
            act_frac_q  <= act_frac_d;
            shd_int_q   <= shd_int_d;
            shd_frac_q  <= shd_frac_d;
            pending_q   <= pending_d;
            err_q       <= err_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            os_tick_q   <= os_tick_d;
            baud_tick_q <= baud_tick_d;
        end
    end

    assign os_tick     = os_tick_q;
    assign baud_tick   = baud_tick_q;
    assign os_phase    = phase_q;
    assign cfg_pending = pending_q;
    assign cfg_err     = err_q;

endmodule

// File: tb/tb_uart_frac_baud_gen.sv
// Directed bench for uart_frac_baud_gen: period pattern, phase, bit length, load/apply, enable and reset.
module tb_uart_frac_baud_gen;

    localparam int OS = 16;
    localparam int FB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [15:0] div_int;
    logic [3:0]  div_frac;
    logic        div_load;
    logic        os_tick;
    logic        baud_tick;
    logic [3:0]  os_phase;
    logic        cfg_pending;
    logic        cfg_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected divisor / accumulator / phase as the bench tracks them.
    int m_int, m_frac, m_acc, m_phase;
    int since_baud, exp_bit;
    bit had_baud;

    uart_frac_baud_gen dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .div_int    (div_int),
        .div_frac   (div_frac),
        .div_load   (div_load),
        .os_tick    (os_tick),
        .baud_tick  (baud_tick),
        .os_phase   (os_phase),
        .cfg_pending(cfg_pending),
        .cfg_err    (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
            $display("ok   %s got=%0d", tag, got);
        end else begin
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        div_load = 1'b0;
        since_baud++;
    endtask

    // Wait for the next os_tick and compare its spacing, phase and bit strobe against the model.
    task automatic expect_tick(input string tag);
        int s, len, n;
        s   = m_acc + m_frac;
        len = m_int + (s >> FB);
        n   = 0;
        do begin
            step();
            n++;
        end while (!os_tick && n < 300);
        check({tag, " gap"}, n, len);
        m_phase = (m_phase + 1) % OS;
        m_acc   = s % (1 << FB);
        check({tag, " phase"}, int'(os_phase), m_phase);
        check({tag, " baud"}, int'(baud_tick), (m_phase == OS - 1) ? 1 : 0);
        if (m_phase == OS - 1) begin
            if (had_baud) check({tag, " bit_len"}, since_baud, exp_bit);
            had_baud   = 1'b1;
            since_baud = 0;
        end
    endtask

    task automatic restart_model(input int bit_len);
        m_acc      = 0;
        m_phase    = 0;
        had_baud   = 1'b0;
        since_baud = 0;
        exp_bit    = bit_len;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int strobes;
        reset    = 1'b1;
        enable   = 1'b0;
        div_int  = '0;
        div_frac = '0;
        div_load = 1'b0;
        repeat (3) @(negedge clk);
        check("rst os_tick", int'(os_tick), 0);
        check("rst baud_tick", int'(baud_tick), 0);
        check("rst os_phase", int'(os_phase), 0);
        check("rst cfg_pending", int'(cfg_pending), 0);
        check("rst cfg_err", int'(cfg_err), 0);

        // Default divisor 3 + 2/16: seven 3-cycle periods then a 4, 50 cycles per bit.
        m_int = 3; m_frac = 2; restart_model(50);
        reset  = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 32; i++) expect_tick("def");

        // Integer divisor 4 loaded while idle is applied on the following edge.
        enable   = 1'b0;
        div_int  = 16'd4;
        div_frac = 4'd0;
        div_load = 1'b1;
        step();
        check("idle load pending", int'(cfg_pending), 1);
        check("idle no tick", int'(os_tick), 0);
        step();
        check("idle apply pending", int'(cfg_pending), 0);
        m_int = 4; m_frac = 0; restart_model(64);
        enable = 1'b1;
        for (int i = 0; i < 32; i++) expect_tick("int4");

        // Load 10 + 8/16 at phase 5; old timing runs until the bit boundary.
        restart_model(168);
        m_phase = 0;
        for (int i = 0; i < 5; i++) expect_tick("pre");
        div_int  = 16'd10;
        div_frac = 4'd8;
        div_load = 1'b1;
        expect_tick("old");
        check("mid load pending", int'(cfg_pending), 1);
        while (m_phase != OS - 1) expect_tick("old");
        m_int = 10; m_frac = 8; m_acc = 0;
        check("boundary apply pending", int'(cfg_pending), 0);
        for (int i = 0; i < 16; i++) expect_tick("frac");

        // Rejected load, then a valid one clears the error.
        enable = 1'b0;
        step();
        div_int  = 16'd1;
        div_load = 1'b1;
        step();
        check("bad load err", int'(cfg_err), 1);
        check("bad load pending", int'(cfg_pending), 0);
        restart_model(0);
        enable = 1'b1;
        expect_tick("kept");
        enable = 1'b0;
        step();
        div_int  = 16'd5;
        div_frac = 4'd0;
        div_load = 1'b1;
        step();
        check("good load err", int'(cfg_err), 0);
        check("good load pending", int'(cfg_pending), 1);
        step();
        check("good apply pending", int'(cfg_pending), 0);

        // Drop enable at phase 7 partway through a period.
        m_int = 5; m_frac = 0; restart_model(80);
        enable = 1'b1;
        for (int i = 0; i < 7; i++) expect_tick("int5");
        step();
        step();
        enable  = 1'b0;
        strobes = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (os_tick || baud_tick) strobes++;
        end
        check("idle strobes", strobes, 0);
        check("idle os_phase", int'(os_phase), 0);
        restart_model(80);
        enable = 1'b1;
        expect_tick("reen");

        // Asynchronous reset mid-bit discards a pending load.
        expect_tick("run");
        expect_tick("run");
        div_int  = 16'd8;
        div_frac = 4'd0;
        div_load = 1'b1;
        step();
        check("pre-rst pending", int'(cfg_pending), 1);
        #2 reset = 1'b1;
        #1;
        check("async os_phase", int'(os_phase), 0);
        check("async cfg_pending", int'(cfg_pending), 0);
        check("async os_tick", int'(os_tick), 0);
        check("async baud_tick", int'(baud_tick), 0);
        @(negedge clk);
        reset = 1'b0;
        m_int = 3; m_frac = 2; restart_model(50);
        for (int i = 0; i < 17; i++) expect_tick("post");
        check("post cfg_pending", int'(cfg_pending), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_frac_baud_gen.md
# uart_frac_baud_gen

Fractional-N, runtime-programmable baud/oversample tick generator for the UART datapath. It replaces the fixed integer divider. It produces a 1-cycle oversample strobe for the RX sampler and a 1-cycle bit strobe for the TX shifter. The divisor can be reprogrammed safely while running, and changes apply only on a bit boundary. The fractional accumulator holds baud error below 1/2^FRAC_BITS of an oversample period, independent of the CLK_FREQ/BAUD ratio.

## Interface
- CLK_FREQ, 50000000: system clock in Hz; used only for the reset-default divisor.
- BAUD_RATE, 1000000: reset-default baud rate.
- OVERSAMPLE, 16: oversample ticks per bit; power of two, 4..64.
- DIV_WIDTH, 16: width of the integer divisor.
- FRAC_BITS, 4: width of the fractional divisor, 1..8.
- clk  in  1  system clock.
- reset  in  1  reset, asynchronous, active-high.
- enable  in  1  run control; low holds the generator idle.
- div_int  in  DIV_WIDTH  requested integer divisor, in clk cycles per oversample tick.
- div_frac  in  FRAC_BITS  requested fractional divisor, in units of 1/2^FRAC_BITS cycle.
- div_load  in  1  1-cycle strobe that captures div_int/div_frac.
- os_tick  out  1  1-cycle oversample strobe.
- baud_tick  out  1  1-cycle bit strobe; coincides with the last os_tick of each bit.
- os_phase  out  clog2(OVERSAMPLE)  index of the current oversample tick within the bit.
- cfg_pending  out  1  a loaded divisor is waiting for the next bit boundary.
- cfg_err  out  1  sticky flag: the last load was rejected.

## Operation
- Default divisor is D0 = round(CLK_FREQ·2^FRAC_BITS / (BAUD_RATE·OVERSAMPLE)), with int = D0 >> FRAC_BITS and frac = D0 mod 2^FRAC_BITS. With the defaults: D0 = 50, giving int 3, frac 2 (3.125 cycles).
- Active registers: act_int, act_frac, acc (FRAC_BITS wide), cnt (DIV_WIDTH wide), phase.
- Oversample period k has length L_k = act_int + c_k. Here c_k is the carry out of acc + act_frac, evaluated at the start of the period. At the end of each period, acc <= (acc + act_frac) mod 2^FRAC_BITS.
- cnt increments each enabled cycle. When cnt == L_k − 1: os_tick <= 1, cnt <= 0, phase <= phase + 1 (wrapping at OVERSAMPLE), and acc updates.
- baud_tick <= 1 on the same edge as os_tick when phase == OVERSAMPLE − 1.
- Load handling: div_load with div_int ≥ 2 captures the values into a shadow register, sets cfg_pending and clears cfg_err.
  - div_load with div_int < 2 is ignored, sets cfg_err and leaves the shadow and cfg_pending unchanged.
- Apply: on the edge that issues baud_tick, or on any edge where enable = 0, a pending shadow is copied to act_* and cfg_pending clears. acc and cnt restart at 0 for the new divisor.
- If div_load and the apply edge coincide, the value in the shadow before the load is applied. The new load stays pending.
- enable = 0: cnt, acc and phase are held at 0, os_tick and baud_tick are 0, and the divisor can still be loaded.

## Timing
- Reset values: os_tick 0, baud_tick 0, os_phase 0, cfg_pending 0, cfg_err 0, act_* = default, acc 0, cnt 0.
- All outputs are registered. Each strobe is exactly one cycle high.
- Starting with enable sampled high and cnt = 0, the first os_tick is high after L_0 rising edges.
- Consecutive os_ticks are L_k cycles apart. A bit spans sum(L_k) over OVERSAMPLE periods. Long-run mean period = act_int + act_frac/2^FRAC_BITS.
- os_phase is updated together with os_tick. It reads OVERSAMPLE−1 during the cycle baud_tick is high, then 0 afterwards.
- enable falling: the strobes are 0 from the next cycle onward and no partial tick is issued.
- enable rising restarts timing from phase 0 and acc 0.
- Reset asserted mid-bit forces every output to its reset value immediately, with no handshake.
- Integer divisor with div_frac = 0 gives a strictly periodic os_tick; c_k is always 0.

## Test plan
- Defaults (int 3, frac 2), enable held high → 16 os_ticks and 1 baud_tick every 50 cycles. The period pattern is seven periods of 3 cycles then one of 4, repeated. os_phase counts 0..15.
- Load int 4, frac 0 while enable = 0 → applied on the next edge. os_tick arrives every 4 cycles and baud_tick every 64 cycles. cfg_pending pulses for 1 cycle.
- Load int 10, frac 8 at phase 5 → cfg_pending = 1. The old timing holds until the next baud_tick; afterwards periods alternate 10/11 cycles and a bit is 168 cycles.
- Load int 1 → cfg_err = 1 and the divisor is unchanged. A following valid load of int 5 → cfg_err = 0.
- Drop enable at phase 7 for 20 cycles, then raise it → no strobes while low. The first os_tick comes L_0 cycles after re-enable with os_phase = 1 after that tick.
- Assert reset mid-bit after a pending load → all outputs and act_* return to defaults and the pending load is discarded.
